// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, reset/bubble constants, fetch FSM encoding
// and the IF/ID payload layout.
package cpu_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned OPC_W = 5;
  localparam int unsigned REG_W = 3;

  localparam logic [OPC_W-1:0] OPC_ADDI = 5'b00011;
  localparam logic [OPC_W-1:0] OPC_BEQ  = 5'b10000;
  localparam logic [OPC_W-1:0] OPC_JAL  = 5'b10010;
  localparam logic [OPC_W-1:0] OPC_LW   = 5'b01101;
  localparam logic [OPC_W-1:0] OPC_SW   = 5'b01110;

  // ADDI R0,R0,0 is the pipeline bubble.
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h1800_0000;
  localparam logic [XLEN-1:0] RESET_PC  = 32'h0000_0000;
  localparam logic [REG_W-1:0] LINK_REG = 3'd7;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic            valid;
  } if_id_t;

  // Instruction addresses are always word aligned.
  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register.
//   clk, reset : clock and synchronous active-high reset
//   load       : capture next (a real fetch)
//   flush      : replace instruction with a bubble, keep pc fields
//   next       : payload captured on load
//   q          : registered payload to decode
// Priority: reset > flush > load > hold.
module if_id_reg
  import cpu_pkg::*;
#(
  parameter logic [31:0] BUBBLE = cpu_pkg::NOP_INSTR
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   load,
  input  logic   flush,
  input  if_id_t next,
  output if_id_t q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q.instr    <= BUBBLE;
      q.pc       <= '0;
      q.pc_plus4 <= '0;
      q.valid    <= 1'b0;
    end else if (flush) begin
      q.instr <= BUBBLE;
      q.valid <= 1'b0;
    end else if (load) begin
      q <= next;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, next-PC select, RUN/HALTED FSM and
// retired-fetch counter; the fetched word is held in the IF/ID register.
//   clk, reset        : clock, synchronous active-high reset
//   imem_addr         : byte address to instruction memory (= pc)
//   imem_instr        : word returned by instruction memory
//   stall             : hold pc and IF/ID
//   redirect_valid/pc : taken branch / jump target from execute
//   halt_req          : stop fetching until reset
//   if_id_*           : registered fetch result to decode
//   halted            : high in HALTED state
//   fetch_count       : number of valid instructions pushed into IF/ID
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = cpu_pkg::RESET_PC,
  parameter logic [31:0] NOP_INSTR = cpu_pkg::NOP_INSTR,
  parameter int unsigned CNT_W     = 32
) (
  input  logic             clk,
  input  logic             reset,
  output logic [31:0]      imem_addr,
  input  logic [31:0]      imem_instr,
  input  logic             stall,
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_pc,
  input  logic             halt_req,
  output logic [31:0]      if_id_instr,
  output logic [31:0]      if_id_pc,
  output logic [31:0]      if_id_pc_plus4,
  output logic             if_id_valid,
  output logic             halted,
  output logic [CNT_W-1:0] fetch_count
);

  import cpu_pkg::*;

  fetch_state_t state;
  logic [31:0]  pc;
  logic [31:0]  pc_plus4;
  logic         running;
  logic         do_fetch;
  logic         do_flush;
  if_id_t       if_id_next;
  if_id_t       if_id_q;

  assign imem_addr = pc;
  assign pc_plus4  = pc + 32'd4;

  // Per-edge priority in RUN: redirect > stall > halt_req > fetch.
  always_comb begin
    running  = (state == ST_RUN);
    do_fetch = 1'b0;
    do_flush = 1'b0;
    if (running) begin
      if (redirect_valid) begin
        do_flush = 1'b1;
      end else if (!stall) begin
        do_flush = halt_req;
        do_fetch = !halt_req;
      end
    end
  end

  always_comb begin
    if_id_next.instr    = imem_instr;
    if_id_next.pc       = pc;
    if_id_next.pc_plus4 = pc_plus4;
    if_id_next.valid    = 1'b1;
  end

  // PC, FSM, halted flag and counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_RUN;
      pc          <= RESET_PC;
      halted      <= 1'b0;
      fetch_count <= '0;
    end else if (state == ST_RUN) begin
      if (redirect_valid) begin
        pc <= align_word(redirect_pc);
      end else if (stall) begin
        pc <= pc;
      end else if (halt_req) begin
        state  <= ST_HALTED;
        halted <= 1'b1;
      end else begin
        pc          <= pc_plus4;
        fetch_count <= fetch_count + CNT_W'(1);
      end
    end
  end

  if_id_reg #(
    .BUBBLE (NOP_INSTR)
  ) u_if_id_reg (
    .clk   (clk),
    .reset (reset),
    .load  (do_fetch),
    .flush (do_flush),
    .next  (if_id_next),
    .q     (if_id_q)
  );

  assign if_id_instr    = if_id_q.instr;
  assign if_id_pc       = if_id_q.pc;
  assign if_id_pc_plus4 = if_id_q.pc_plus4;
  assign if_id_valid    = if_id_q.valid;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios with literal
// expectations plus randomized control traffic against a behavioural model.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h1800_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        halt_req = 1'b0;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc_plus4;
  logic        if_id_valid;
  logic        halted;
  logic [31:0] fetch_count;

  logic [31:0] mem [0:1023];

  int n_checks = 0;
  int n_errors = 0;

  // Model state.
  logic [31:0] m_pc, m_instr, m_ifpc, m_plus4, m_cnt;
  logic        m_valid, m_halted;

  always #5 clk = ~clk;

  assign imem_instr = mem[imem_addr[11:2]];

  fetch_unit #(
    .RESET_PC  (32'h0000_0000),
    .NOP_INSTR (NOP),
    .CNT_W     (32)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt_req       (halt_req),
    .if_id_instr    (if_id_instr),
    .if_id_pc       (if_id_pc),
    .if_id_pc_plus4 (if_id_pc_plus4),
    .if_id_valid    (if_id_valid),
    .halted         (halted),
    .fetch_count    (fetch_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("imem_addr", imem_addr, m_pc);
    chk("if_id_instr", if_id_instr, m_instr);
    chk("if_id_pc", if_id_pc, m_ifpc);
    chk("if_id_pc_plus4", if_id_pc_plus4, m_plus4);
    chk("if_id_valid", 32'(if_id_valid), 32'(m_valid));
    chk("halted", 32'(halted), 32'(m_halted));
    chk("fetch_count", fetch_count, m_cnt);
  endtask

  // What one clock edge must do, straight from the stage's rules.
  task automatic model_edge();
    if (reset) begin
      m_pc = 32'h0; m_instr = NOP; m_ifpc = 0; m_plus4 = 0;
      m_valid = 1'b0; m_cnt = 0; m_halted = 1'b0;
    end else if (m_halted) begin
      // frozen
    end else if (redirect_valid) begin
      m_pc = redirect_pc & 32'hFFFF_FFFC;
      m_instr = NOP; m_valid = 1'b0;
    end else if (stall) begin
      // hold
    end else if (halt_req) begin
      m_instr = NOP; m_valid = 1'b0; m_halted = 1'b1;
    end else begin
      m_instr = mem[m_pc[11:2]];
      m_ifpc  = m_pc;
      m_plus4 = m_pc + 32'd4;
      m_valid = 1'b1;
      m_pc    = m_pc + 32'd4;
      m_cnt   = m_cnt + 32'd1;
    end
  endtask

  // Called at a negedge: drive, advance the model, then check after the edge.
  task automatic cycle(input logic rst, input logic stl, input logic rv,
                       input logic [31:0] rpc, input logic hr);
    reset = rst; stall = stl; redirect_valid = rv; redirect_pc = rpc; halt_req = hr;
    model_edge();
    @(negedge clk);
    check_model();
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    for (int i = 0; i < 16; i++) mem[i] = 32'hAAAA_0000 + 32'(i);
    m_pc = 'x; m_instr = 'x; m_ifpc = 'x; m_plus4 = 'x; m_cnt = 'x;
    m_valid = 1'bx; m_halted = 1'bx;

    @(negedge clk);

    // Reset state.
    cycle(1, 0, 0, 0, 0);
    chk("rst_valid", 32'(if_id_valid), 32'd0);
    chk("rst_instr", if_id_instr, 32'h1800_0000);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_count", fetch_count, 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);

    // Four free-run fetches.
    for (int i = 0; i < 4; i++) begin
      cycle(0, 0, 0, 0, 0);
      chk("run_pc", if_id_pc, 32'(4 * i));
      chk("run_instr", if_id_instr, 32'hAAAA_0000 + 32'(i));
    end
    chk("run_count", fetch_count, 32'd4);
    chk("run_plus4", if_id_pc_plus4, 32'd16);

    // Stall at pc=8.
    cycle(1, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 1, 0, 0, 0);
      chk("stall_addr", imem_addr, 32'h8);
      chk("stall_ifpc", if_id_pc, 32'h4);
      chk("stall_count", fetch_count, 32'd2);
    end
    cycle(0, 0, 0, 0, 0);
    chk("unstall_ifpc", if_id_pc, 32'h8);
    chk("unstall_instr", if_id_instr, 32'hAAAA_0002);

    // Redirect with simultaneous stall.
    cycle(0, 1, 1, 32'h24, 0);
    chk("redir_addr", imem_addr, 32'h24);
    chk("redir_valid", 32'(if_id_valid), 32'd0);
    chk("redir_instr", if_id_instr, 32'h1800_0000);
    cycle(0, 0, 0, 0, 0);
    chk("redir_ifpc", if_id_pc, 32'h24);
    chk("redir_valid1", 32'(if_id_valid), 32'd1);

    // Misaligned target.
    cycle(0, 0, 1, 32'h27, 0);
    chk("align_addr", imem_addr, 32'h24);

    // Halt at pc=0x10, then pulses that must be ignored.
    cycle(1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 1);
    chk("halt_flag", 32'(halted), 32'd1);
    chk("halt_addr", imem_addr, 32'h10);
    for (int i = 0; i < 12; i++)
      cycle(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
    chk("halt_addr_end", imem_addr, 32'h10);
    chk("halt_valid_end", 32'(if_id_valid), 32'd0);
    chk("halt_count_end", fetch_count, 32'd4);
    cycle(1, 0, 0, 0, 0);
    chk("unhalt_addr", imem_addr, 32'h0);
    chk("unhalt_flag", 32'(halted), 32'd0);

    // PC wrap at the top of the address space.
    cycle(0, 0, 1, 32'hFFFF_FFFC, 0);
    cycle(0, 0, 0, 0, 0);
    chk("wrap_addr", imem_addr, 32'h0);
    chk("wrap_plus4", if_id_pc_plus4, 32'h0);
    chk("wrap_ifpc", if_id_pc, 32'hFFFF_FFFC);

    // Randomized control traffic.
    for (int i = 0; i < 3000; i++) begin
      logic r, s, v, h;
      r = ($urandom_range(0, 99) == 0);
      s = ($urandom_range(0, 4) == 0);
      v = ($urandom_range(0, 9) == 0);
      h = ($urandom_range(0, 149) == 0);
      cycle(r, s, v, $urandom, h);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
